// File: rtl/cr_field_file_if.sv
// Bus bundle for the CR field file: issue/hazard handshake, retire ports
// (compare, writeback, CR-logical) and the registered CR / pending views.
interface cr_field_file_if;
  logic        iss_vld;
  logic [0:7]  iss_wr_oh;
  logic [0:7]  iss_rd_oh;
  logic        stall;
  logic        cmp_vld;
  logic [0:7]  cmp_fld_oh;
  logic [0:3]  cmp_res;
  logic        wb_vld;
  logic [0:7]  wb_mask;
  logic [0:31] wb_data;
  logic        crop_vld;
  logic [0:2]  crop_op;
  logic [0:4]  crop_ba;
  logic [0:4]  crop_bb;
  logic [0:4]  crop_bt;
  logic [0:31] cr_out;
  logic [0:7]  pend_out;

  modport master (
    output iss_vld, iss_wr_oh, iss_rd_oh,
    output cmp_vld, cmp_fld_oh, cmp_res,
    output wb_vld, wb_mask, wb_data,
    output crop_vld, crop_op, crop_ba, crop_bb, crop_bt,
    input  stall, cr_out, pend_out
  );

  modport slave (
    input  iss_vld, iss_wr_oh, iss_rd_oh,
    input  cmp_vld, cmp_fld_oh, cmp_res,
    input  wb_vld, wb_mask, wb_data,
    input  crop_vld, crop_op, crop_ba, crop_bb, crop_bt,
    output stall, cr_out, pend_out
  );
endinterface

// File: rtl/cr_field_file.sv
// PowerPC condition register file with per-field writer scoreboard,
// RAW/WAW issue stall and a two-stage CR-logical pipeline. Big-endian bit order.
module cr_field_file #(
  parameter logic [0:31] RST_VAL = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  cr_field_file_if.slave bus
);

  logic [0:31] cr_q, cr_d, cr_fld_s;
  logic [0:7]  pend_q, pend_d;
  logic        c_vld_q, c_vld_d;
  logic        c_bit_q, c_bit_d;
  logic [0:4]  c_bt_q, c_bt_d;
  logic [0:7]  haz_s, pend_clr_s, pend_set_s;
  logic        stall_s;

  function automatic logic [0:7] fld_oh(input logic [0:2] idx);
    logic [0:7] oh;
    oh      = 8'h00;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic crop_eval(input logic [0:2] op, input logic a, input logic b);
    logic r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      3'b111:  r = a | ~b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // An in-flight crop target counts as an outstanding writer of its field.
  always_comb begin
    if (c_vld_q) begin
      haz_s = pend_q | fld_oh(c_bt_q[0:2]);
    end else begin
      haz_s = pend_q;
    end
    stall_s = bus.iss_vld & (|((bus.iss_rd_oh | bus.iss_wr_oh) & haz_s));
  end

  // Next CR: crop stage 2 beats cmp, cmp beats wb.
  always_comb begin
    cr_fld_s = cr_q;
    for (int i = 0; i < 8; i++) begin
      if (bus.cmp_vld && bus.cmp_fld_oh[i]) begin
        cr_fld_s[4*i +: 4] = bus.cmp_res;
      end else if (bus.wb_vld && bus.wb_mask[i]) begin
        cr_fld_s[4*i +: 4] = bus.wb_data[4*i +: 4];
      end else begin
        cr_fld_s[4*i +: 4] = cr_q[4*i +: 4];
      end
    end
    cr_d = cr_fld_s;
    if (c_vld_q) begin
      cr_d[c_bt_q] = c_bit_q;
    end else begin
      cr_d[c_bt_q] = cr_fld_s[c_bt_q];
    end
  end

  // Scoreboard: an accepted issue sets its fields after all clears.
  always_comb begin
    pend_clr_s = 8'h00;
    if (bus.wb_vld) begin
      pend_clr_s = pend_clr_s | bus.wb_mask;
    end else begin
      pend_clr_s = pend_clr_s;
    end
    if (bus.cmp_vld) begin
      pend_clr_s = pend_clr_s | bus.cmp_fld_oh;
    end else begin
      pend_clr_s = pend_clr_s;
    end
    if (c_vld_q) begin
      pend_clr_s = pend_clr_s | fld_oh(c_bt_q[0:2]);
    end else begin
      pend_clr_s = pend_clr_s;
    end
    if (bus.iss_vld && !stall_s) begin
      pend_set_s = bus.iss_wr_oh;
    end else begin
      pend_set_s = 8'h00;
    end
    pend_d = (pend_q & ~pend_clr_s) | pend_set_s;
  end

  // Crop stage 1 reads sources from the registered CR only.
  always_comb begin
    if (bus.crop_vld) begin
      c_vld_d = 1'b1;
      c_bit_d = crop_eval(bus.crop_op, cr_q[bus.crop_ba], cr_q[bus.crop_bb]);
      c_bt_d  = bus.crop_bt;
    end else begin
      c_vld_d = 1'b0;
      c_bit_d = c_bit_q;
      c_bt_d  = c_bt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q    <= RST_VAL;
      pend_q  <= 8'h00;
      c_vld_q <= 1'b0;
      c_bit_q <= 1'b0;
      c_bt_q  <= 5'd0;
    end else begin
      cr_q    <= cr_d;
      pend_q  <= pend_d;
      c_vld_q <= c_vld_d;
      c_bit_q <= c_bit_d;
      c_bt_q  <= c_bt_d;
    end
  end

  assign bus.stall    = stall_s;
  assign bus.cr_out   = cr_q;
  assign bus.pend_out = pend_q;

endmodule

// File: tb/tb_cr_field_file.sv
// Bench for cr_field_file: directed vector table, mid-operation reset,
// then randomized traffic against a field-level reference model.
module tb_cr_field_file;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cr_field_file_if bus ();

  cr_field_file #(.RST_VAL(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [7:0]  wr;
    logic [7:0]  rd;
    logic        cv;
    logic [7:0]  coh;
    logic [3:0]  cres;
    logic        wv;
    logic [7:0]  wm;
    logic [31:0] wd;
    logic        kv;
    logic [2:0]  op;
    logic [4:0]  ba;
    logic [4:0]  bb;
    logic [4:0]  bt;
    logic        e_stall;
    logic [31:0] e_cr;
    logic [7:0]  e_pend;
  } vec_t;

  typedef struct {
    int bt;
    bit v;
  } crop_t;

  // Reference model state: eight 4-bit fields, pending flags, in-flight crops.
  logic [3:0] m_fld [8];
  bit         m_pend [8];
  crop_t      m_cq [$];
  // Truth tables indexed by {a,b}.
  logic [3:0] tt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] wr, input logic [7:0] rd,
                              input logic cv, input logic [7:0] coh, input logic [3:0] cres,
                              input logic wv, input logic [7:0] wm, input logic [31:0] wd,
                              input logic kv, input logic [2:0] op, input logic [4:0] ba,
                              input logic [4:0] bb, input logic [4:0] bt,
                              input logic es, input logic [31:0] ecr, input logic [7:0] ep);
    vec_t x;
    x.iv = iv; x.wr = wr; x.rd = rd; x.cv = cv; x.coh = coh; x.cres = cres;
    x.wv = wv; x.wm = wm; x.wd = wd; x.kv = kv; x.op = op; x.ba = ba; x.bb = bb;
    x.bt = bt; x.e_stall = es; x.e_cr = ecr; x.e_pend = ep;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    bus.iss_vld = x.iv;   bus.iss_wr_oh = x.wr;   bus.iss_rd_oh = x.rd;
    bus.cmp_vld = x.cv;   bus.cmp_fld_oh = x.coh; bus.cmp_res = x.cres;
    bus.wb_vld = x.wv;    bus.wb_mask = x.wm;     bus.wb_data = x.wd;
    bus.crop_vld = x.kv;  bus.crop_op = x.op;     bus.crop_ba = x.ba;
    bus.crop_bb = x.bb;   bus.crop_bt = x.bt;
  endtask

  task automatic idle();
    drive(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0, 0, 3'd0, 5'd0, 5'd0, 5'd0,
             0, 32'h0, 8'h00));
  endtask

  // Vector is driven one delta after posedge; stall sampled at negedge, state after next posedge.
  task automatic apply(input vec_t x, input int idx);
    drive(x);
    @(negedge clk);
    chk($sformatf("v%0d stall", idx), {31'd0, bus.stall}, {31'd0, x.e_stall});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cr_out", idx), bus.cr_out, x.e_cr);
    chk($sformatf("v%0d pend_out", idx), {24'd0, bus.pend_out}, {24'd0, x.e_pend});
  endtask

  function automatic logic m_bit(input int k);
    return m_fld[k / 4][3 - (k % 4)];
  endfunction

  function automatic logic [31:0] m_cr();
    logic [31:0] v;
    v = 32'h0;
    for (int f = 0; f < 8; f++) v = (v << 4) | {28'd0, m_fld[f]};
    return v;
  endfunction

  function automatic logic [7:0] m_pendv();
    logic [7:0] v;
    v = 8'h00;
    for (int f = 0; f < 8; f++) v = (v << 1) | {7'd0, m_pend[f]};
    return v;
  endfunction

  function automatic logic m_stall();
    bit hit;
    hit = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if ((bus.iss_rd_oh[f] || bus.iss_wr_oh[f]) &&
          (m_pend[f] || (m_cq.size() > 0 && m_cq[0].bt / 4 == f)))
        hit = 1'b1;
    end
    return bus.iss_vld && hit;
  endfunction

  // Advance the model one clock; writes applied lowest priority first.
  task automatic model_edge(input logic stl);
    logic [3:0] nf [8];
    bit         np [8];
    crop_t      nc;
    bit         have_new;
    for (int f = 0; f < 8; f++) begin
      nf[f] = m_fld[f];
      np[f] = m_pend[f];
      if (bus.wb_vld && bus.wb_mask[f]) begin
        nf[f] = bus.wb_data[4*f +: 4];
        np[f] = 1'b0;
      end
      if (bus.cmp_vld && bus.cmp_fld_oh[f]) begin
        nf[f] = bus.cmp_res;
        np[f] = 1'b0;
      end
    end
    if (m_cq.size() > 0) begin
      nf[m_cq[0].bt / 4][3 - (m_cq[0].bt % 4)] = m_cq[0].v;
      np[m_cq[0].bt / 4] = 1'b0;
      void'(m_cq.pop_front());
    end
    have_new = bus.crop_vld;
    if (have_new) begin
      nc.bt = int'(bus.crop_bt);
      nc.v  = tt[bus.crop_op][{m_bit(int'(bus.crop_ba)), m_bit(int'(bus.crop_bb))}];
      m_cq.push_back(nc);
    end
    for (int f = 0; f < 8; f++) begin
      if (bus.iss_vld && !stl && bus.iss_wr_oh[f]) np[f] = 1'b1;
      m_fld[f]  = nf[f];
      m_pend[f] = np[f];
    end
  endtask

  vec_t vt [$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1101;

    idle();
    rst_n = 1'b0;
    #12;
    chk("reset cr_out", bus.cr_out, 32'h8000_0000);
    chk("reset pend_out", {24'd0, bus.pend_out}, 32'h0);
    chk("reset stall", {31'd0, bus.stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //        iv wr     rd     cv coh    cres  wv wm     wd            kv op    ba     bb     bt     es cr            pend
    vt.push_back(mk(1, 8'h20, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h8000_0000, 8'h20));
    vt.push_back(mk(1, 8'h00, 8'h20, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  1, 32'h8000_0000, 8'h20));
    vt.push_back(mk(0, 8'h00, 8'h00, 1, 8'h20, 4'h2, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h8020_0000, 8'h00));
    vt.push_back(mk(1, 8'h00, 8'h20, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h8020_0000, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 1, 8'hFF, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h0000_0000, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 1, 8'h81, 32'hA000_0005, 0, 3'd0, 5'd0, 5'd0,  5'd0,  0, 32'hA000_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 1, 8'h7E, 32'h0123_4560, 0, 3'd0, 5'd0, 5'd0,  5'd0,  0, 32'hA123_4565, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 1, 8'h81, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h0123_4560, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 1, 8'hFF, 32'hC000_0000, 0, 3'd0, 5'd0, 5'd0,  5'd0,  0, 32'hC000_0000, 8'h00));
    vt.push_back(mk(1, 8'h01, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd0, 5'd0,  5'd1,  5'd31, 0, 32'hC000_0000, 8'h01));
    vt.push_back(mk(1, 8'h00, 8'h01, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  1, 32'hC000_0001, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd4, 5'd2,  5'd3,  5'd29, 0, 32'hC000_0001, 8'h00));
    vt.push_back(mk(1, 8'h00, 8'h01, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  1, 32'hC000_0005, 8'h00));
    vt.push_back(mk(1, 8'h00, 8'h01, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'hC000_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 1, 8'h80, 4'hF, 1, 8'hC0, 32'h0500_0000, 0, 3'd0, 5'd0, 5'd0,  5'd0,  0, 32'hF500_0005, 8'h00));
    vt.push_back(mk(1, 8'h10, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'hF500_0005, 8'h10));
    vt.push_back(mk(1, 8'h10, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  1, 32'hF500_0005, 8'h10));
    vt.push_back(mk(1, 8'h20, 8'h00, 0, 8'h00, 4'h0, 1, 8'h20, 32'h0030_0000, 0, 3'd0, 5'd0, 5'd0,  5'd0,  0, 32'hF530_0005, 8'h30));
    vt.push_back(mk(0, 8'h00, 8'h00, 1, 8'h30, 4'h6, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'hF566_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd2, 5'd0,  5'd4,  5'd8,  0, 32'hF566_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 1, 8'h20, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'hF586_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd5, 5'd8,  5'd9,  5'd0,  0, 32'hF586_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd6, 5'd0,  5'd31, 5'd1,  0, 32'h7586_0005, 8'h00));
    vt.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        0, 3'd0, 5'd0,  5'd0,  5'd0,  0, 32'h3586_0005, 8'h00));
    vt.push_back(mk(1, 8'h01, 8'h00, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,        1, 3'd7, 5'd0,  5'd1,  5'd30, 0, 32'h3586_0005, 8'h01));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Asynchronous reset with a pending field and a crop in flight.
    bus.iss_vld   = 1'b1;
    bus.iss_rd_oh = 8'h01;
    bus.iss_wr_oh = 8'h00;
    bus.crop_vld  = 1'b0;
    #1;
    chk("pre-reset stall", {31'd0, bus.stall}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset cr_out", bus.cr_out, 32'h8000_0000);
    chk("midreset pend_out", {24'd0, bus.pend_out}, 32'h0);
    chk("midreset stall", {31'd0, bus.stall}, 32'h0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset cr_out", bus.cr_out, 32'h8000_0000);
    chk("postreset pend_out", {24'd0, bus.pend_out}, 32'h0);

    // Randomized phase against the field model.
    for (int f = 0; f < 8; f++) begin
      m_fld[f]  = (f == 0) ? 4'h8 : 4'h0;
      m_pend[f] = 1'b0;
    end
    m_cq.delete();
    for (int n = 0; n < 3000; n++) begin
      logic stl;
      bus.iss_vld    = ($urandom_range(0, 1) == 0);
      bus.iss_wr_oh  = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'h80 >> $urandom_range(0, 7));
      bus.iss_rd_oh  = 8'(($urandom_range(0, 1) == 0) ? (8'h80 >> $urandom_range(0, 7)) : 8'h00)
                     | 8'(($urandom_range(0, 3) == 0) ? (8'h80 >> $urandom_range(0, 7)) : 8'h00);
      bus.cmp_vld    = ($urandom_range(0, 3) == 0);
      bus.cmp_fld_oh = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h80 >> $urandom_range(0, 7));
      bus.cmp_res    = 4'($urandom);
      bus.wb_vld     = ($urandom_range(0, 5) == 0);
      bus.wb_mask    = 8'($urandom);
      bus.wb_data    = 32'($urandom);
      bus.crop_vld   = ($urandom_range(0, 2) == 0);
      bus.crop_op    = 3'($urandom);
      bus.crop_ba    = 5'($urandom);
      bus.crop_bb    = 5'($urandom);
      bus.crop_bt    = 5'($urandom);
      @(negedge clk);
      stl = m_stall();
      chk("rand stall", {31'd0, bus.stall}, {31'd0, stl});
      model_edge(stl);
      @(posedge clk);
      #1;
      chk("rand cr_out", bus.cr_out, m_cr());
      chk("rand pend_out", {24'd0, bus.pend_out}, {24'd0, m_pendv()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
